// File: rtl/sevenseg_mux_if.sv
// Display-side bundle for the multiplexed seven-segment driver.
// master = datapath/bench side, slave = sevenseg_mux.
interface sevenseg_mux_if #(
    parameter int NDIGITS = 4
) ();
    logic [4*NDIGITS-1:0] data;
    logic [NDIGITS-1:0]   dp_in;
    logic                 load;
    logic                 lzb;
    logic [6:0]           segments;
    logic                 dp;
    logic [NDIGITS-1:0]   anodes;
    logic                 pending;
    logic                 frame_tick;

    modport master (
        output data, dp_in, load, lzb,
        input  segments, dp, anodes, pending, frame_tick
    );

    modport slave (
        input  data, dp_in, load, lzb,
        output segments, dp, anodes, pending, frame_tick
    );
endinterface

// File: rtl/sevenseg_mux.sv
// Time-multiplexed NDIGITS seven-segment driver with frame-synchronous
// double buffering, per-digit decimal points and leading-zero blanking.
module sevenseg_mux #(
    parameter int NDIGITS     = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic          clk,
    input  logic          reset,
    sevenseg_mux_if.slave bus
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IMAX = IW'(NDIGITS - 1);

    logic [PW-1:0]        r_presc;
    logic [IW-1:0]        r_idx;
    logic [4*NDIGITS-1:0] r_sh_data;
    logic [NDIGITS-1:0]   r_sh_dp;
    logic [4*NDIGITS-1:0] r_disp_data;
    logic [NDIGITS-1:0]   r_disp_dp;
    logic                 r_pending;
    logic                 r_frame_tick;
    logic [6:0]           r_seg;
    logic                 r_dp;
    logic [NDIGITS-1:0]   r_an;

    logic                 w_tc;
    logic                 w_wrap;
    logic [3:0]           w_nib;
    logic                 w_dp;
    logic [NDIGITS-1:0]   w_an;
    logic                 w_zero;
    logic                 w_blank;
    logic [6:0]           w_seg;

    assign w_tc   = (r_presc == PMAX);
    assign w_wrap = w_tc && (r_idx == IMAX);

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h7E;
            4'h1: s = 7'h30;
            4'h2: s = 7'h6D;
            4'h3: s = 7'h79;
            4'h4: s = 7'h33;
            4'h5: s = 7'h5B;
            4'h6: s = 7'h5F;
            4'h7: s = 7'h70;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h7B;
            4'hA: s = 7'h77;
            4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;
            4'hD: s = 7'h3D;
            4'hE: s = 7'h4F;
            default: s = 7'h47;
        endcase
        return s;
    endfunction

    // Scan from the top digit down; w_zero tracks "this and all higher are 0".
    always_comb begin
        w_nib   = 4'h0;
        w_dp    = 1'b0;
        w_an    = '0;
        w_zero  = 1'b1;
        w_blank = 1'b0;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            w_zero = w_zero && (r_disp_data[4*i +: 4] == 4'h0);
            if (r_idx == IW'(i)) begin
                w_nib   = r_disp_data[4*i +: 4];
                w_dp    = r_disp_dp[i];
                w_an[i] = 1'b1;
                w_blank = bus.lzb && w_zero && (i != 0);
            end
        end
        w_seg = w_blank ? 7'h00 : decode(w_nib);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_sh_data    <= '0;
            r_sh_dp      <= '0;
            r_disp_data  <= '0;
            r_disp_dp    <= '0;
            r_pending    <= 1'b0;
            r_frame_tick <= 1'b0;
            r_seg        <= '0;
            r_dp         <= 1'b0;
            r_an         <= '0;
        end else begin
            r_presc      <= w_tc ? '0 : r_presc + 1'b1;
            r_frame_tick <= w_wrap;
            if (w_tc)
                r_idx <= (r_idx == IMAX) ? '0 : r_idx + 1'b1;
            if (bus.load) begin
                r_sh_data <= bus.data;
                r_sh_dp   <= bus.dp_in;
            end
            // A load on the wrap edge bypasses the shadow straight to display.
            if (w_wrap) begin
                r_disp_data <= bus.load ? bus.data  : r_sh_data;
                r_disp_dp   <= bus.load ? bus.dp_in : r_sh_dp;
                r_pending   <= 1'b0;
            end else if (bus.load) begin
                r_pending <= 1'b1;
            end
            r_seg <= w_seg;
            r_dp  <= w_dp;
            r_an  <= w_an;
        end
    end

    assign bus.segments   = (ACTIVE_LOW != 0) ? ~r_seg : r_seg;
    assign bus.dp         = (ACTIVE_LOW != 0) ? ~r_dp  : r_dp;
    assign bus.anodes     = (ACTIVE_LOW != 0) ? ~r_an  : r_an;
    assign bus.pending    = r_pending;
    assign bus.frame_tick = r_frame_tick;
endmodule

// File: tb/tb_sevenseg_mux.sv
// Bench for sevenseg_mux: 4-digit active-high and active-low instances in
// lockstep against a frame-arithmetic model, plus a 1-digit decode sweep.
module tb_sevenseg_mux;
    localparam int N = 4;
    localparam int R = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_m;
    logic rst_b;

    sevenseg_mux_if #(.NDIGITS(4)) ifa ();
    sevenseg_mux_if #(.NDIGITS(4)) ifc ();
    sevenseg_mux_if #(.NDIGITS(1)) ifb ();

    sevenseg_mux #(.NDIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(0)) u_a (
        .clk(clk), .reset(rst_m), .bus(ifa.slave));
    sevenseg_mux #(.NDIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1)) u_c (
        .clk(clk), .reset(rst_m), .bus(ifc.slave));
    sevenseg_mux #(.NDIGITS(1), .REFRESH_DIV(1), .ACTIVE_LOW(0)) u_b (
        .clk(clk), .reset(rst_b), .bus(ifb.slave));

    typedef struct {
        logic [3:0] nib;
        logic [6:0] seg;
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic [6:0] tbl [16];
    vec_t       vecs [16];

    // Model state: m_t counts non-reset edges, so idx and wrap are plain arithmetic.
    int          m_t;
    logic [15:0] m_sh, m_disp;
    logic [3:0]  m_shdp, m_dispdp;
    logic        m_pend;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_an;
    logic        e_ft;

    logic [15:0] d_data;
    logic [3:0]  d_dp;
    logic        d_ld, d_lz;

    task automatic set_in(input logic ld, input logic [15:0] d,
                          input logic [3:0] dp, input logic lz);
        d_ld = ld; d_data = d; d_dp = dp; d_lz = lz;
        ifa.load = ld; ifa.data = d; ifa.dp_in = dp; ifa.lzb = lz;
        ifc.load = ld; ifc.data = d; ifc.dp_in = dp; ifc.lzb = lz;
    endtask

    task automatic model_edge();
        int          idx;
        logic        wrap;
        logic [15:0] up;
        if (rst_m) begin
            m_t = 0; m_sh = '0; m_shdp = '0; m_disp = '0; m_dispdp = '0;
            m_pend = 1'b0; e_seg = '0; e_dp = 1'b0; e_an = '0; e_ft = 1'b0;
        end else begin
            idx   = (m_t / R) % N;
            wrap  = (m_t % (R * N)) == (R * N - 1);
            up    = m_disp >> (4 * idx);
            e_an  = 4'(1 << idx);
            e_seg = (d_lz && idx != 0 && up == 16'h0) ? 7'h00 : tbl[up[3:0]];
            e_dp  = m_dispdp[idx];
            e_ft  = wrap;
            if (wrap) begin
                m_disp   = d_ld ? d_data : m_sh;
                m_dispdp = d_ld ? d_dp : m_shdp;
                m_pend   = 1'b0;
            end else if (d_ld) begin
                m_pend = 1'b1;
            end
            if (d_ld) begin
                m_sh = d_data; m_shdp = d_dp;
            end
            m_t++;
        end
    endtask

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic tick(input string nm);
        logic [13:0] ea, aa, ec, ac;
        model_edge();
        @(posedge clk);
        #1;
        ea = {e_seg, e_dp, e_an, m_pend, e_ft};
        ec = {~e_seg, ~e_dp, ~e_an, m_pend, e_ft};
        aa = {ifa.segments, ifa.dp, ifa.anodes, ifa.pending, ifa.frame_tick};
        ac = {ifc.segments, ifc.dp, ifc.anodes, ifc.pending, ifc.frame_tick};
        total += 2;
        if (aa !== ea) begin
            bad++;
            $display("FAIL %s dut_a t=%0d got=%h want=%h", nm, m_t, aa, ea);
        end
        if (ac !== ec) begin
            bad++;
            $display("FAIL %s dut_c t=%0d got=%h want=%h", nm, m_t, ac, ec);
        end
    endtask

    initial begin
        int ft_cnt;
        tbl = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        vecs[0]  = '{4'h0, 7'h7E}; vecs[1]  = '{4'h1, 7'h30};
        vecs[2]  = '{4'h2, 7'h6D}; vecs[3]  = '{4'h3, 7'h79};
        vecs[4]  = '{4'h4, 7'h33}; vecs[5]  = '{4'h5, 7'h5B};
        vecs[6]  = '{4'h6, 7'h5F}; vecs[7]  = '{4'h7, 7'h70};
        vecs[8]  = '{4'h8, 7'h7F}; vecs[9]  = '{4'h9, 7'h7B};
        vecs[10] = '{4'hA, 7'h77}; vecs[11] = '{4'hB, 7'h1F};
        vecs[12] = '{4'hC, 7'h4E}; vecs[13] = '{4'hD, 7'h3D};
        vecs[14] = '{4'hE, 7'h4F}; vecs[15] = '{4'hF, 7'h47};

        ifb.load = 1'b0; ifb.data = '0; ifb.dp_in = '0; ifb.lzb = 1'b0;
        set_in(1'b0, 16'h0, 4'h0, 1'b0);
        rst_m = 1'b1;
        rst_b = 1'b1;
        repeat (3) tick("reset");
        chk("rst_pend", 16'(ifa.pending), 16'h0);
        chk("rst_seg", 16'(ifa.segments), 16'h00);
        chk("rst_an", 16'(ifa.anodes), 16'h0);
        chk("rst_c_seg", 16'(ifc.segments), 16'h7F);
        chk("rst_c_an", 16'(ifc.anodes), 16'hF);
        chk("rst_c_dp", 16'(ifc.dp), 16'h1);

        rst_m = 1'b0;
        rst_b = 1'b0;
        tick("release");
        chk("first_an", 16'(ifa.anodes), 16'h1);
        chk("first_seg", 16'(ifa.segments), 16'h7E);
        chk("first_c_an", 16'(ifc.anodes), 16'hE);
        chk("first_c_seg", 16'(ifc.segments), 16'h01);
        chk("b_an", 16'(ifb.anodes), 16'h1);

        ft_cnt = 0;
        for (int k = 0; k < 32; k++) begin
            tick("idle");
            if (ifa.frame_tick) ft_cnt++;
        end
        chk("ft_count", 16'(ft_cnt), 16'd2);

        // Load mid-frame while idx==1: must not show until the wrap.
        for (int k = 0; k < 20 && ((m_t / R) % N) != 1; k++) tick("align1");
        set_in(1'b1, 16'h1234, 4'h0, 1'b0);
        tick("ld1234");
        set_in(1'b0, 16'h0, 4'h0, 1'b0);
        chk("pend_mid", 16'(ifa.pending), 16'h1);
        repeat (40) tick("tear");
        chk("pend_after", 16'(ifa.pending), 16'h0);

        // Load on the wrap edge itself.
        for (int k = 0; k < 20 && (m_t % (R * N)) != (R * N - 1); k++) tick("align_w");
        set_in(1'b1, 16'hABCD, 4'h0, 1'b0);
        tick("ld_wrap");
        set_in(1'b0, 16'h0, 4'h0, 1'b0);
        chk("pend_coinc", 16'(ifa.pending), 16'h0);
        repeat (20) tick("abcd");

        set_in(1'b1, 16'h0070, 4'h0, 1'b1);
        tick("ld0070");
        set_in(1'b0, 16'h0, 4'h0, 1'b1);
        repeat (36) tick("lzb70");
        set_in(1'b1, 16'h0000, 4'h0, 1'b1);
        tick("ld0000");
        set_in(1'b0, 16'h0, 4'h0, 1'b1);
        repeat (36) tick("lzb0");
        set_in(1'b0, 16'h0, 4'h0, 1'b0);
        repeat (20) tick("nolzb");
        set_in(1'b1, 16'h0000, 4'b1000, 1'b1);
        tick("ld_dp3");
        set_in(1'b0, 16'h0, 4'b1000, 1'b1);
        repeat (36) tick("lzb_dp");

        // Reset mid-frame with a pending load.
        for (int k = 0; k < 20 && (m_t % (R * N)) != 5; k++) tick("align5");
        set_in(1'b1, 16'h5A5A, 4'hF, 1'b0);
        tick("ld_prerst");
        set_in(1'b0, 16'h0, 4'h0, 1'b0);
        chk("pend_prerst", 16'(ifa.pending), 16'h1);
        rst_m = 1'b1;
        tick("midrst");
        chk("midrst_c_seg", 16'(ifc.segments), 16'h7F);
        chk("midrst_c_an", 16'(ifc.anodes), 16'hF);
        chk("midrst_c_dp", 16'(ifc.dp), 16'h1);
        chk("midrst_pend", 16'(ifa.pending), 16'h0);
        rst_m = 1'b0;
        repeat (20) tick("postrst");

        for (int k = 0; k < 400; k++) begin
            set_in($urandom_range(0, 7) == 0, 16'($urandom), 4'($urandom),
                   1'($urandom));
            rst_m = ($urandom_range(0, 79) == 0);
            tick("rand");
        end
        rst_m = 1'b0;

        // Single digit, divide-by-1: every edge is a wrap edge.
        for (int i = 0; i < 16; i++) begin
            ifb.data = vecs[i].nib;
            ifb.load = 1'b1;
            @(posedge clk);
            #1;
            chk("b_pend", 16'(ifb.pending), 16'h0);
            ifb.load = 1'b0;
            @(posedge clk);
            #1;
            chk($sformatf("b_dec%0h", vecs[i].nib), 16'(ifb.segments),
                16'(vecs[i].seg));
        end
        chk("b_an_end", 16'(ifb.anodes), 16'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
